uart_tx_fifo: RTL and testbench

//  Synchronous first-word-fall-through FIFO that buffers bytes for the UART transmitter.
//  The producer (CPU/bus side) writes bytes; the UART transmitter consumes them via empty/rd_data/rd_en.
//  rd_en is driven by the transmitter's one-cycle start pulse, which latches rd_data in the same cycle.

---
 rtl/uart_tx_fifo.sv | 94 +++++++++
 tb/tb_uart_tx_fifo.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter; a write is visible on rd_data one cycle later.
// Writes while full are dropped unless a pop happens in the same cycle; sticky overflow/underflow flags record misuse.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AFULL = 14
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_acc, rd_acc;

    always_comb begin
        // A pop frees the head slot in the same cycle, so a full FIFO can still take a write.
        wr_acc      = wr_en & (~full_q | rd_en);
        rd_acc      = rd_en & ~empty_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Flags come from the next count so they never lag the registered count.
        empty_d     = (count_d == '0);
        full_d      = (count_d == CW'(DEPTH));
        afull_d     = (count_d >= CW'(AFULL));
        overflow_d  = (wr_en & full_q & ~rd_en) | (overflow_q & ~clr_err);
        underflow_d = (rd_en & empty_q) | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            afull_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            afull_q     <= afull_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data     = mem_q[rd_ptr_q];
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus randomized traffic against a queue-based model.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic       full, almost_full, empty, overflow, underflow;
    logic [7:0] rd_data;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    bit         m_ov = 1'b0;
    bit         m_un = 1'b0;

    uart_tx_fifo #(.WIDTH(8), .DEPTH(16), .AFULL(14)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end

    // Apply one cycle of stimulus, advance the model by the same cycle, and sample 1ns after the edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c, input logic rs);
        bit was_full, was_empty;
        wr_en = w; wr_data = d; rd_en = r; clr_err = c; rst = rs;
        was_full  = (mq.size() == 16);
        was_empty = (mq.size() == 0);
        if (rs) begin
            mq.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
        end else begin
            if (r && !was_empty) void'(mq.pop_front());
            if (w && (!was_full || r)) mq.push_back(d);
            if (w && was_full && !r) m_ov = 1'b1;
            else if (c) m_ov = 1'b0;
            if (r && was_empty) m_un = 1'b1;
            else if (c) m_un = 1'b0;
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        cyc(0, 8'h00, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 1);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %b want 0", almost_full); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_unf got %b want 0", underflow); end
    endtask

    task automatic test_single();
        cyc(1, 8'hA5, 0, 0, 0);
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", empty); end
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", rd_data); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
        cyc(0, 8'h00, 1, 0, 0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_pop_empty got %b want 1", empty); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_pop_count got %0d want 0", count); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            cyc(1, 8'(i), 0, 0, 0);
            checks++; if (count !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
            checks++; if (almost_full !== (i + 1 >= 14)) begin errors++; $display("FAIL fill_afull[%0d] got %b want %b", i, almost_full, (i + 1 >= 14)); end
            checks++; if (full !== (i + 1 == 16)) begin errors++; $display("FAIL fill_full[%0d] got %b want %b", i, full, (i + 1 == 16)); end
        end
        cyc(1, 8'hFF, 0, 0, 0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d want 16", count); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (rd_data !== 8'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h want %h", i, rd_data, 8'(i)); end
            cyc(0, 8'h00, 1, 0, 0);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", empty); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_full_rw();
        cyc(0, 8'h00, 0, 1, 0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
        for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + i), 0, 0, 0);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL frw_full_pre got %b want 1", full); end
        cyc(1, 8'h55, 1, 0, 0);
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL frw_count got %0d want 16", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL frw_full got %b want 1", full); end
        checks++; if (rd_data !== 8'h11) begin errors++; $display("FAIL frw_head got %h want 11", rd_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL frw_ovf got %b want 0", overflow); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (rd_data !== mq[0]) begin errors++; $display("FAIL frw_drain[%0d] got %h want %h", i, rd_data, mq[0]); end
            if (i == 15) begin
                checks++; if (rd_data !== 8'h55) begin errors++; $display("FAIL frw_last got %h want 55", rd_data); end
            end
            cyc(0, 8'h00, 1, 0, 0);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL frw_empty got %b want 1", empty); end
    endtask

    task automatic test_underflow();
        cyc(0, 8'h00, 1, 0, 0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_set got %b want 1", underflow); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL unf_count got %0d want 0", count); end
        cyc(0, 8'h00, 1, 1, 0);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_set_beats_clr got %b want 1", underflow); end
        cyc(0, 8'h00, 0, 1, 0);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clr got %b want 0", underflow); end
        cyc(1, 8'h77, 1, 0, 0);
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL unf_wr_count got %0d want 1", count); end
        checks++; if (rd_data !== 8'h77) begin errors++; $display("FAIL unf_wr_data got %h want 77", rd_data); end
        checks++; if (underflow !== m_un) begin errors++; $display("FAIL unf_wr_flag got %b want %b", underflow, m_un); end
        cyc(0, 8'h00, 1, 1, 0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL unf_final_empty got %b want 1", empty); end
    endtask

    task automatic test_random_wrap();
        logic w, r;
        logic [7:0] d;
        cyc(1, 8'($urandom), 0, 0, 0);
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom);
            r = 1'($urandom);
            d = 8'($urandom);
            if (mq.size() <= 1 && r && !w) r = 1'b0;
            if (mq.size() >= 15 && w && !r) w = 1'b0;
            checks++; if (rd_data !== mq[0]) begin errors++; $display("FAIL rnd_data[%0d] got %h want %h", n, rd_data, mq[0]); end
            cyc(w, d, r, 0, 0);
            checks++; if (count !== 5'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, count, mq.size()); end
            checks++; if (almost_full !== (mq.size() >= 14)) begin errors++; $display("FAIL rnd_afull[%0d] got %b want %b", n, almost_full, (mq.size() >= 14)); end
        end
        cyc(1, 8'hC3, 0, 0, 1);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty got %b want 1", empty); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL mid_rst_count got %0d want 0", count); end
        cyc(1, 8'h3C, 0, 0, 0);
        checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL post_rst_data got %h want 3c", rd_data); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL post_rst_count got %0d want 1", count); end
        cyc(0, 8'h00, 1, 0, 0);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL post_rst_empty got %b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_rw();
        test_underflow();
        test_random_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
